// File: rtl/mult_fi_pkg.sv
// Shared types and helpers for the fault-injectable
// sequential shift-add multiplier.
package mult_fi_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int FS_ACC_LSB = 0;

   function automatic int fs_sum_lsb(input int w);
      return 2 * w;
   endfunction

   function automatic logic apply_fault(
      input logic net,
      input logic places,
      input logic control
   );
      return (net & ~places) | (control & places);
   endfunction

endpackage

// File: rtl/mult_seq_fi_if.sv
// Start/busy/done handshake and operand/result bus
// for the sequential fault-injectable multiplier.
interface mult_seq_fi_if #(
   parameter int WIDTH = 5
);
   logic                 start;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   out;
   logic                 mismatch;

   modport master (
      output start, A, B,
      input  busy, done, out, mismatch
   );

   modport slave (
      input  start, A, B,
      output busy, done, out, mismatch
   );
endinterface

// File: rtl/mult_seq_fi_fault_mux.sv
// Per-bit stuck-at override of an internal net:
// enabled sites are forced to their control value.
module fault_mux
   import mult_fi_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] net,
   input  logic [N-1:0] places,
   input  logic [N-1:0] control,
   output logic [N-1:0] y
);

   always_comb begin
      y = '0;
      for (int i = 0; i < N; i++) begin
         y[i] = apply_fault(net[i], places[i], control[i]);
      end
   end

endmodule

// File: rtl/mult_seq_fi.sv
// Sequential shift-add unsigned multiplier with stuck-at
// fault sites on the accumulator and adder, plus golden check.
module mult_seq_fi
   import mult_fi_pkg::*;
#(
   parameter  int WIDTH = 5,
   localparam int NF    = 3 * WIDTH + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NF-1:0] fault_places,
   input  logic [NF-1:0] fault_control,
   mult_seq_fi_if.slave  bus
);

   localparam int W2     = 2 * WIDTH;
   localparam int CW     = $clog2(WIDTH);
   localparam int FS_SUM = fs_sum_lsb(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [W2-1:0]   gold_q, gold_d;
   logic [W2-1:0]   out_q, out_d;
   logic            mis_q, mis_d;

   logic [W2-1:0]   acc_f;
   logic [WIDTH:0]  sum_raw, sum_f;
   logic [W2-1:0]   step;
   logic            is_run, accept;

   fault_mux #(.N(W2)) u_acc_fm (
      .net     (acc_q),
      .places  (fault_places[FS_ACC_LSB +: W2]),
      .control (fault_control[FS_ACC_LSB +: W2]),
      .y       (acc_f)
   );

   fault_mux #(.N(WIDTH + 1)) u_sum_fm (
      .net     (sum_raw),
      .places  (fault_places[FS_SUM +: WIDTH + 1]),
      .control (fault_control[FS_SUM +: WIDTH + 1]),
      .y       (sum_f)
   );

   // Carry lands in sum[WIDTH]; shift right one per step.
   always_comb begin
      sum_raw = {1'b0, acc_f[W2-1:WIDTH]}
              + (acc_f[0] ? {1'b0, a_q} : '0);
      step    = {sum_f, acc_f[WIDTH-1:1]};
   end

   assign is_run = (state_q == S_RUN);
   assign accept = bus.start && !is_run;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      acc_d   = acc_q;
      gold_d  = gold_q;
      out_d   = out_q;
      mis_d   = mis_q;
      unique case (1'b1)
         accept: begin
            state_d = S_RUN;
            cnt_d   = '0;
            a_d     = bus.A;
            acc_d   = {{WIDTH{1'b0}}, bus.B};
            gold_d  = W2'(bus.A) * W2'(bus.B);
         end
         is_run: begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               out_d   = step;
               mis_d   = (step != gold_q);
            end
         end
         default: begin
            if (state_q == S_DONE) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         acc_q   <= '0;
         gold_q  <= '0;
         out_q   <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         gold_q  <= gold_d;
         out_q   <= out_d;
         mis_q   <= mis_d;
      end
   end

   assign bus.busy     = is_run;
   assign bus.done     = (state_q == S_DONE);
   assign bus.out      = out_q;
   assign bus.mismatch = mis_q;

endmodule

// File: tb/tb_mult_seq_fi.sv
// Scoreboard bench for mult_seq_fi: directed handshake and fault
// cases plus random ops against an arithmetic reference model.
module tb_mult_seq_fi;

   localparam int W  = 5;
   localparam int NF = 3 * W + 1;
   localparam int W2 = 2 * W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NF-1:0] fp = '0;
   logic [NF-1:0] fc = '0;

   mult_seq_fi_if #(.WIDTH(W)) bus ();

   mult_seq_fi #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fault_places  (fp),
      .fault_control (fc),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W2-1:0] out;
      logic          mis;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   ndone  = 0;
   int   npush  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act,
                        input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Shift-add product with stuck-at faults, as plain arithmetic.
   function automatic void model(
      input  longint a, input longint b,
      input  logic [NF-1:0] pl, input logic [NF-1:0] ct,
      output logic [W2-1:0] o, output logic m);
      longint acc, af, s, pa, ca, ps, cs;
      pa  = longint'(pl[W2-1:0]);
      ca  = longint'(ct[W2-1:0]);
      ps  = longint'(pl[3*W:W2]);
      cs  = longint'(ct[3*W:W2]);
      acc = b;
      for (int i = 0; i < W; i++) begin
         af  = (acc & ~pa) | (ca & pa);
         s   = (af >> W) + ((af % 2 == 1) ? a : 0);
         s   = (s & ~ps) | (cs & ps);
         acc = s * (longint'(1) << (W - 1)) + (af % (longint'(1) << W)) / 2;
      end
      o = W2'(acc);
      m = (acc != a * b);
   endfunction

   always @(negedge clk) begin
      if (bus.done) begin
         ndone++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no op pending");
         end else begin
            mon_e = sb.pop_front();
            check("out", longint'(bus.out), longint'(mon_e.out));
            check("mismatch", longint'(bus.mismatch), longint'(mon_e.mis));
            check("latency", cyc, mon_e.cyc);
         end
      end
   end

   task automatic op(input int a, input int b,
                     input logic [NF-1:0] pl, input logic [NF-1:0] ct);
      int n;
      logic [W2-1:0] o;
      logic m;
      n = 0;
      while (bus.busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("busy_timeout", 1, 0);
      fp = pl;
      fc = ct;
      bus.A = W'(a);
      bus.B = W'(b);
      bus.start = 1'b1;
      model(a, b, pl, ct, o, m);
      sb.push_back('{o, m, cyc + 1 + W});
      npush++;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("drain_timeout", 1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [NF-1:0] z;
      logic [NF-1:0] p1;
      int n;
      z = '0;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_out", bus.out, 0);
      check("rst_mismatch", bus.mismatch, 0);
      rst_n = 1'b1;
      @(negedge clk);

      op(31, 31, z, z);
      drain();
      repeat (2) @(negedge clk);
      check("hold_out", bus.out, 961);
      check("idle_done", bus.done, 0);
      op(27, 18, z, z);
      drain();
      check("out_486", bus.out, 486);

      p1 = '0;
      p1[5] = 1'b1;
      op(0, 0, p1, p1);
      drain();
      check("acc5_detect", bus.mismatch, 1);
      check("acc5_out_nonzero", longint'(bus.out != 0), 1);

      p1 = '0;
      p1[15] = 1'b1;
      op(31, 31, p1, z);
      drain();
      check("sum15_out_wrong", longint'(bus.out != 961), 1);
      check("sum15_detect", bus.mismatch, 1);
      op(0, 7, p1, z);
      drain();
      check("sum15_undetected", bus.mismatch, 0);

      op(29, 24, z, z);
      repeat (2) @(negedge clk);
      bus.A = W'(1);
      bus.B = W'(1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      check("ignore_midrun", bus.out, 696);

      op(5, 6, z, z);
      n = 0;
      while (!bus.done && n < 50) begin
         @(negedge clk);
         n++;
      end
      op(7, 9, z, z);
      check("b2b_busy", bus.busy, 1);
      drain();

      op(9, 9, z, z);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      sb.delete();
      npush--;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_out", bus.out, 0);
      check("abort_mismatch", bus.mismatch, 0);
      rst_n = 1'b1;
      @(negedge clk);
      op(4, 16, z, z);
      drain();
      check("after_abort", bus.out, 64);

      for (int i = 0; i < 200; i++) begin
         op($urandom_range(0, (1 << W) - 1),
            $urandom_range(0, (1 << W) - 1), z, z);
      end
      for (int i = 0; i < 200; i++) begin
         op($urandom_range(0, (1 << W) - 1),
            $urandom_range(0, (1 << W) - 1),
            NF'($urandom & $urandom & $urandom), NF'($urandom));
      end
      drain();
      repeat (3) @(negedge clk);
      check("done_count", ndone, npush);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
